systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 142 ++++++++++++++
 tb/tb_systolic_feeder.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Purpose: feeds weight rows and row-skewed activation vectors into a ROWS x COLS systolic array.
// Latency: weight beat to north bus 1 cycle; activation lane r to west edge r+1 cycles.
// Backpressure: valid/ready on both inputs; ready comes only from the phase (LOAD or ARM/STREAM), never from the array.
module systolic_feeder #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           cfg_mode,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [COLS*DW-1:0]   w_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [ROWS*DW-1:0]   x_data,
  input  logic                 x_last,
  output logic [COLS*DW-1:0]   col_weight,
  output logic [COLS-1:0]      col_accept_w,
  output logic [ROWS*DW-1:0]   row_input,
  output logic [ROWS-1:0]      row_valid,
  output logic [ROWS-1:0]      row_switch,
  output logic                 array_enable,
  output logic [1:0]           sys_mode,
  output logic                 busy,
  output logic                 done
);

  // Drain covers the longest delay line plus a full pass through the array.
  localparam int DRAIN_LEN = ROWS + COLS;
  localparam int WCW       = $clog2(ROWS + 1);
  localparam int DCW       = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WCW-1:0] w_cnt;
  logic [DCW-1:0] d_cnt;
  logic           w_acc;
  logic           x_acc;
  logic           switch_in;

  assign w_acc     = w_valid & w_ready;
  assign x_acc     = x_valid & x_ready;
  // Only the first vector after ARM tells the array to swap in the new weights.
  assign switch_in = x_acc & (state == S_ARM);

  // Next-state decode plus the phase-derived handshake and status outputs.
  always_comb begin
    state_nxt    = state;
    w_ready      = 1'b0;
    x_ready      = 1'b0;
    busy         = 1'b1;
    array_enable = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy         = 1'b0;
        array_enable = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_valid && (w_cnt == WCW'(ROWS - 1))) state_nxt = S_ARM;
      end
      S_ARM: begin
        x_ready = 1'b1;
        if (x_valid) state_nxt = x_last ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        x_ready = 1'b1;
        if (x_valid && x_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (d_cnt == DCW'(DRAIN_LEN - 1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters, latched mode, done pulse and the registered north weight bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      w_cnt        <= '0;
      d_cnt        <= '0;
      sys_mode     <= 2'b00;
      done         <= 1'b0;
      col_weight   <= '0;
      col_accept_w <= '0;
    end else begin
      state        <= state_nxt;
      done         <= (state == S_DRAIN) && (state_nxt == S_IDLE);
      col_accept_w <= {COLS{w_acc}};
      col_weight   <= w_acc ? w_data : '0;
      if (state == S_IDLE && start) sys_mode <= cfg_mode;
      // Beat counter only runs in LOAD, so a new job always starts from zero.
      if (state != S_LOAD) w_cnt <= '0;
      else if (w_acc)      w_cnt <= w_cnt + 1'b1;
      if (state != S_DRAIN) d_cnt <= '0;
      else                  d_cnt <= d_cnt + 1'b1;
    end
  end

  // One skew line per row; row r is r+1 stages deep so the array sees a diagonal wavefront.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] dat_q [0:r];
    logic [r:0]    vld_q;
    logic [r:0]    sw_q;

    // Shift every cycle; cycles without an accepted vector push a zero bubble.
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int s = 0; s <= r; s++) dat_q[s] <= '0;
        vld_q <= '0;
        sw_q  <= '0;
      end else begin
        dat_q[0] <= x_acc ? x_data[r*DW +: DW] : '0;
        vld_q[0] <= x_acc;
        sw_q[0]  <= switch_in;
        for (int s = 1; s <= r; s++) begin
          dat_q[s] <= dat_q[s-1];
          vld_q[s] <= vld_q[s-1];
          sw_q[s]  <= sw_q[s-1];
        end
      end
    end

    assign row_input[r*DW +: DW] = dat_q[r];
    assign row_valid[r]          = vld_q[r];
    assign row_switch[r]         = sw_q[r];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder in a 2x2 configuration: directed scenarios plus
// randomized jobs checked against a per-cycle schedule of expected outputs.
module tb_systolic_feeder;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int DW   = 16;
  localparam int MAXC = 4096;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [1:0]          cfg_mode;
  logic                w_valid;
  logic                w_ready;
  logic [COLS*DW-1:0]  w_data;
  logic                x_valid;
  logic                x_ready;
  logic [ROWS*DW-1:0]  x_data;
  logic                x_last;
  logic [COLS*DW-1:0]  col_weight;
  logic [COLS-1:0]     col_accept_w;
  logic [ROWS*DW-1:0]  row_input;
  logic [ROWS-1:0]     row_valid;
  logic [ROWS-1:0]     row_switch;
  logic                array_enable;
  logic [1:0]          sys_mode;
  logic                busy;
  logic                done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected-output schedule indexed by absolute cycle number (zero = bubble / idle).
  logic               exp_v  [MAXC][ROWS];
  logic               exp_s  [MAXC][ROWS];
  logic [DW-1:0]      exp_d  [MAXC][ROWS];
  logic [COLS*DW-1:0] exp_cw [MAXC];
  logic               exp_ca [MAXC];

  systolic_feeder #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
    .col_weight(col_weight), .col_accept_w(col_accept_w),
    .row_input(row_input), .row_valid(row_valid), .row_switch(row_switch),
    .array_enable(array_enable), .sys_mode(sys_mode), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_job(input logic [1:0] mode);
    start = 1'b1; cfg_mode = mode;
    step();
    start = 1'b0;
    w_valid = 1'b1;
    for (int k = 0; k < ROWS; k++) begin
      w_data = $urandom;
      step();
    end
    w_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({col_weight, col_accept_w, row_input, row_valid, row_switch, array_enable,
         sys_mode, busy, done, w_ready, x_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b ready=%b/%b sys_mode=%b rows=%h cw=%h, want all 0",
               busy, w_ready, x_ready, sys_mode, row_input, col_weight);
    end
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || array_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b done=%b en=%b, want 0 0 0", busy, done, array_enable);
    end
  endtask

  task automatic test_load();
    int n;
    start = 1'b1; cfg_mode = 2'b10;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || w_ready !== 1'b1 || x_ready !== 1'b0 || sys_mode !== 2'b10 || col_accept_w !== 2'b00) begin
      errors++;
      $display("FAIL load_entry: busy=%b w_ready=%b x_ready=%b mode=%b acc=%b, want 1 1 0 10 00",
               busy, w_ready, x_ready, sys_mode, col_accept_w);
    end
    w_valid = 1'b1; w_data = 32'h0102_0304;
    step();
    checks++;
    if (col_accept_w !== 2'b11 || col_weight !== 32'h0102_0304 || w_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_beat0: acc=%b cw=%h w_ready=%b, want 11 01020304 1", col_accept_w, col_weight, w_ready);
    end
    w_data = 32'h0506_0708;
    step();
    checks++;
    if (col_accept_w !== 2'b11 || col_weight !== 32'h0506_0708 || w_ready !== 1'b0 || x_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_beat1_arm: acc=%b cw=%h w_ready=%b x_ready=%b, want 11 05060708 0 1",
               col_accept_w, col_weight, w_ready, x_ready);
    end
    w_data = 32'hdead_beef;
    step();
    checks++;
    if (col_accept_w !== 2'b00 || col_weight !== '0) begin
      errors++;
      $display("FAIL load_extra_beat_ignored: acc=%b cw=%h, want 00 0", col_accept_w, col_weight);
    end
    w_valid = 1'b0;
    x_valid = 1'b1; x_last = 1'b1; x_data = $urandom;
    step();
    x_valid = 1'b0; x_last = 1'b0;
    wait_idle(n);
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL load_job_timeout: busy still %b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    load_job(2'b10);
    x_valid = 1'b1; x_last = 1'b0; x_data = {16'h0022, 16'h0011};
    step();
    x_last = 1'b1; x_data = {16'h0044, 16'h0033};
    checks++;
    if (row_input !== {16'h0000, 16'h0011} || row_valid !== 2'b01 || row_switch !== 2'b01) begin
      errors++;
      $display("FAIL b2b_T1: rows=%h v=%b s=%b, want 00000011 01 01", row_input, row_valid, row_switch);
    end
    step();
    x_valid = 1'b0; x_last = 1'b0;
    checks++;
    if (row_input !== {16'h0022, 16'h0033} || row_valid !== 2'b11 || row_switch !== 2'b10) begin
      errors++;
      $display("FAIL b2b_T2: rows=%h v=%b s=%b, want 00220033 11 10", row_input, row_valid, row_switch);
    end
    step();
    checks++;
    if (row_input !== {16'h0044, 16'h0000} || row_valid !== 2'b10 || row_switch !== 2'b00) begin
      errors++;
      $display("FAIL b2b_T3: rows=%h v=%b s=%b, want 00440000 10 00", row_input, row_valid, row_switch);
    end
    wait_idle(n);
    checks++;
    if (n >= 50 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: waited=%0d done=%b, want <50 and 1", n, done);
    end
  endtask

  task automatic test_bubble();
    int n;
    load_job(2'b10);
    x_valid = 1'b1; x_last = 1'b0; x_data = {16'h0b0b, 16'h0a0a};
    step();
    x_valid = 1'b0;
    checks++;
    if (row_input !== {16'h0000, 16'h0a0a} || row_valid !== 2'b01 || row_switch !== 2'b01) begin
      errors++;
      $display("FAIL bubble_T1: rows=%h v=%b s=%b, want 00000a0a 01 01", row_input, row_valid, row_switch);
    end
    step();
    x_valid = 1'b1; x_last = 1'b1; x_data = {16'h0d0d, 16'h0c0c};
    checks++;
    if (row_input !== {16'h0b0b, 16'h0000} || row_valid !== 2'b10 || row_switch !== 2'b10) begin
      errors++;
      $display("FAIL bubble_T2: rows=%h v=%b s=%b, want 0b0b0000 10 10", row_input, row_valid, row_switch);
    end
    step();
    x_valid = 1'b0; x_last = 1'b0;
    checks++;
    if (row_input !== {16'h0000, 16'h0c0c} || row_valid !== 2'b01 || row_switch !== 2'b00) begin
      errors++;
      $display("FAIL bubble_T3: rows=%h v=%b s=%b, want 00000c0c 01 00", row_input, row_valid, row_switch);
    end
    step();
    checks++;
    if (row_input !== {16'h0d0d, 16'h0000} || row_valid !== 2'b10 || row_switch !== 2'b00) begin
      errors++;
      $display("FAIL bubble_T4: rows=%h v=%b s=%b, want 0d0d0000 10 00", row_input, row_valid, row_switch);
    end
    wait_idle(n);
  endtask

  task automatic test_single_drain();
    int n;
    logic [ROWS-1:0] ev;
    load_job(2'b10);
    x_valid = 1'b1; x_last = 1'b1; x_data = $urandom;
    step();
    x_data = 32'hffff_ffff;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      ev = (n == 0) ? 2'b01 : (n == 1) ? 2'b10 : 2'b00;
      checks++;
      if (row_valid !== ev || x_ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL drain_cycle%0d: v=%b x_ready=%b done=%b, want %b 0 0", n, row_valid, x_ready, done, ev);
      end
      step();
      n++;
    end
    x_valid = 1'b0; x_last = 1'b0;
    checks++;
    if (n !== ROWS + COLS || done !== 1'b1 || busy !== 1'b0 || sys_mode !== 2'b10) begin
      errors++;
      $display("FAIL drain_len_done: cycles=%0d done=%b busy=%b mode=%b, want %0d 1 0 10",
               n, done, busy, sys_mode, ROWS + COLS);
    end
    step();
    checks++;
    if (done !== 1'b0 || sys_mode !== 2'b10) begin
      errors++;
      $display("FAIL done_one_cycle: done=%b mode=%b, want 0 10", done, sys_mode);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    load_job(2'b10);
    x_valid = 1'b1; x_last = 1'b0; x_data = $urandom;
    step();
    x_valid = 1'b0;
    start = 1'b1; cfg_mode = 2'b11; w_valid = 1'b1; w_data = $urandom;
    step();
    start = 1'b0; w_valid = 1'b0;
    checks++;
    if (sys_mode !== 2'b10 || busy !== 1'b1 || x_ready !== 1'b1 || w_ready !== 1'b0 || col_accept_w !== 2'b00) begin
      errors++;
      $display("FAIL start_while_busy: mode=%b busy=%b x_ready=%b w_ready=%b acc=%b, want 10 1 1 0 00",
               sys_mode, busy, x_ready, w_ready, col_accept_w);
    end
    x_valid = 1'b1; x_last = 1'b1;
    step();
    x_valid = 1'b0; x_last = 1'b0;
    wait_idle(n);
    step();
    checks++;
    if (n >= 50 || sys_mode !== 2'b10) begin
      errors++;
      $display("FAIL mode_hold_after_job: waited=%0d mode=%b, want <50 10", n, sys_mode);
    end
  endtask

  task automatic test_reset_midjob();
    int n;
    start = 1'b1; cfg_mode = 2'b01;
    step();
    start = 1'b0; w_valid = 1'b1; w_data = $urandom;
    step();
    w_valid = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if ({col_weight, col_accept_w, row_input, row_valid, row_switch, array_enable,
         sys_mode, busy, done, w_ready, x_ready} !== '0) begin
      errors++;
      $display("FAIL midjob_reset_outputs: busy=%b acc=%b mode=%b done=%b, want all 0",
               busy, col_accept_w, sys_mode, done);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midjob_no_done: done=%b busy=%b, want 0 0", done, busy);
    end
    start = 1'b1; cfg_mode = 2'b11;
    step();
    start = 1'b0; w_valid = 1'b1; w_data = $urandom;
    step();
    checks++;
    if (w_ready !== 1'b1 || x_ready !== 1'b0) begin
      errors++;
      $display("FAIL reload_after_one_beat: w_ready=%b x_ready=%b, want 1 0", w_ready, x_ready);
    end
    step();
    w_valid = 1'b0;
    checks++;
    if (w_ready !== 1'b0 || x_ready !== 1'b1 || sys_mode !== 2'b11) begin
      errors++;
      $display("FAIL reload_full: w_ready=%b x_ready=%b mode=%b, want 0 1 11", w_ready, x_ready, sys_mode);
    end
    x_valid = 1'b1; x_last = 1'b1; x_data = $urandom;
    step();
    x_valid = 1'b0; x_last = 1'b0;
    wait_idle(n);
    checks++;
    if (n >= 50 || done !== 1'b1) begin
      errors++;
      $display("FAIL reload_job_done: waited=%0d done=%b, want <50 1", n, done);
    end
  endtask

  task automatic test_random();
    int phase, beats, nvec, sent, budget, done_cyc;
    logic [1:0] mode;
    for (int job = 0; job < 8; job++) begin
      mode = 2'($urandom_range(0, 3));
      nvec = $urandom_range(1, 6);
      start = 1'b1; cfg_mode = mode;
      step();
      start = 1'b0; cfg_mode = ~mode;
      phase = 1; beats = 0; sent = 0; budget = 0; done_cyc = MAXC - 1;
      while (!(phase == 3 && cyc > done_cyc) && budget < 400) begin
        for (int r = 0; r < ROWS; r++) begin
          checks++;
          if (row_valid[r] !== exp_v[cyc][r] || row_switch[r] !== exp_s[cyc][r] ||
              row_input[r*DW +: DW] !== exp_d[cyc][r]) begin
            errors++;
            $display("FAIL rand_row%0d cyc=%0d: v=%b s=%b d=%h, want v=%b s=%b d=%h", r, cyc,
                     row_valid[r], row_switch[r], row_input[r*DW +: DW], exp_v[cyc][r], exp_s[cyc][r], exp_d[cyc][r]);
          end
        end
        checks++;
        if (col_accept_w !== {COLS{exp_ca[cyc]}} || col_weight !== exp_cw[cyc] || sys_mode !== mode ||
            done !== (phase == 3 && cyc == done_cyc) || busy !== !(phase == 3 && cyc == done_cyc)) begin
          errors++;
          $display("FAIL rand_ctrl cyc=%0d: acc=%b cw=%h mode=%b done=%b busy=%b, want acc=%b cw=%h mode=%b done=%b",
                   cyc, col_accept_w, col_weight, sys_mode, done, busy, exp_ca[cyc], exp_cw[cyc], mode,
                   (phase == 3 && cyc == done_cyc));
        end
        checks++;
        if (w_ready !== (phase == 1) || x_ready !== (phase == 2)) begin
          errors++;
          $display("FAIL rand_ready cyc=%0d phase=%0d: w_ready=%b x_ready=%b", cyc, phase, w_ready, x_ready);
        end
        w_valid = ($urandom_range(0, 3) != 0);
        w_data  = $urandom;
        x_valid = ($urandom_range(0, 2) != 0);
        x_data  = $urandom;
        x_last  = 1'($urandom_range(0, 1));
        start   = (phase != 3) && ($urandom_range(0, 7) == 0);
        cfg_mode = 2'($urandom_range(0, 3));
        if (phase == 1) begin
          if (w_valid) begin
            exp_cw[cyc+1] = w_data;
            exp_ca[cyc+1] = 1'b1;
            beats++;
            if (beats == ROWS) phase = 2;
          end
        end else if (phase == 2) begin
          x_last = x_valid ? (sent == nvec - 1) : x_last;
          if (x_valid) begin
            for (int r = 0; r < ROWS; r++) begin
              exp_v[cyc+r+1][r] = 1'b1;
              exp_s[cyc+r+1][r] = (sent == 0);
              exp_d[cyc+r+1][r] = x_data[r*DW +: DW];
            end
            sent++;
            if (sent == nvec) begin
              done_cyc = cyc + 1 + ROWS + COLS;
              phase = 3;
            end
          end
        end
        step();
        budget++;
      end
      {w_valid, x_valid, x_last, start} = '0;
      checks++;
      if (budget >= 400) begin
        errors++;
        $display("FAIL rand_job%0d_timeout: phase=%0d after %0d cycles", job, phase, budget);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      exp_cw[c] = '0;
      exp_ca[c] = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        exp_v[c][r] = 1'b0;
        exp_s[c][r] = 1'b0;
        exp_d[c][r] = '0;
      end
    end
    rst = 1'b0; start = 1'b0; cfg_mode = 2'b00;
    w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0; x_last = 1'b0;
    test_reset();
    test_load();
    test_back_to_back();
    test_bubble();
    test_single_drain();
    test_start_ignored();
    test_reset_midjob();
    step();
    step();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
